// File: rtl/fir_feeder.sv
// fir_feeder: buffers upstream samples and runs them one at a time through a handshake FIR filter.
// Latency: one cycle from a non-empty FIFO to fir_act, then the filter round trip plus one cycle to out_valid.
// Backpressure: in_ready drops when the FIFO is full; no new sample issues while a result is unconsumed.
//
// Ports:
//   clk, reset_n               rising-edge clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  upstream sample stream (push on in_valid & in_ready)
//   fir_x/fir_act              sample and one-cycle start pulse to the filter
//   fir_ready/fir_y            filter idle/done flag and its result
//   out_data/out_valid/out_ready  captured result (consume on out_valid & out_ready)
//   err                        sticky filter timeout flag
//   sample_cnt                 completed-result counter, wraps at 16 bits

// ---------------------------------------------------------------------------
// fir_feeder_fifo: small synchronous FIFO with an occupancy count.
// Latency: a pushed word is visible on rdata the cycle after the push.
// Backpressure: push while full and pop while empty are ignored.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   push/wdata     write request and data
//   pop            read request (head advances)
//   rdata          current head of the FIFO (valid when count != 0)
//   count          number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fir_feeder_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && (count != FULL_CNT);
  assign pop_ok  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// ---------------------------------------------------------------------------
// fir_feeder top level.
// ---------------------------------------------------------------------------
module fir_feeder #(
  parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
  parameter int TIMEOUT = 63   // max cycles waiting for the filter after fir_act
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] fir_x,
  output logic        fir_act,
  input  logic        fir_ready,
  input  logic [15:0] fir_y,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err,
  output logic [15:0] sample_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // Counter value seen on the last allowed waiting cycle.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [15:0]   x_hold;
  logic [TW-1:0] tmo_cnt;

  logic          fifo_push;
  logic          fifo_pop;
  logic [15:0]   fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          start;

  assign in_ready   = (fifo_count != FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_push  = in_valid && in_ready;

  // A sample starts only when the filter is idle and the previous result has
  // been taken, so a captured result can never be overwritten.
  assign start    = (state == IDLE) && !fifo_empty && fir_ready && !out_valid;
  assign fifo_pop = start;

  // The sample stays on fir_x for the whole transaction; it only moves on a pop.
  assign fir_x = x_hold;

  fir_feeder_fifo #(
    .W     (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (in_data),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fir_act    <= 1'b0;
      x_hold     <= '0;
      tmo_cnt    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      sample_cnt <= '0;
    end else begin
      // Consumption first; a capture later in this block cannot coincide
      // with a pending result, but ordering keeps the set dominant anyway.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          fir_act <= 1'b0;
          if (start) begin
            x_hold  <= fifo_rdata;
            tmo_cnt <= '0;
            fir_act <= 1'b1;
            state   <= ISSUE;
          end
        end

        ISSUE: begin
          // fir_act was raised on entry; it lasts exactly this one cycle.
          fir_act <= 1'b0;
          state   <= WAIT_ACK;
        end

        WAIT_ACK: begin
          fir_act <= 1'b0;
          tmo_cnt <= tmo_cnt + 1'b1;
          // A filter acknowledge on the last allowed cycle still counts.
          if (!fir_ready) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end

        WAIT_DONE: begin
          fir_act <= 1'b0;
          tmo_cnt <= tmo_cnt + 1'b1;
          if (fir_ready) begin
            out_data   <= fir_y;
            out_valid  <= 1'b1;
            sample_cnt <= sample_cnt + 16'd1;
            state      <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abandon the sample: no result, no count, keep going.
            err   <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          fir_act <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_feeder.sv
module tb_fir_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] fir_x;
  logic        fir_act;
  logic        fir_ready;
  logic [15:0] fir_y;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic [15:0] sample_cnt;

  fir_feeder #(.DEPTH(4), .TIMEOUT(63)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fir_x      (fir_x),
    .fir_act    (fir_act),
    .fir_ready  (fir_ready),
    .fir_y      (fir_y),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  // Filter stub: ready drops the cycle after act, returns after stub_lat cycles, y = x + 1.
  int stub_lat  = 36;
  bit stub_hang = 1'b0;
  int stub_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fir_ready <= 1'b1;
      fir_y     <= '0;
      stub_cnt  <= 0;
    end else if (fir_ready) begin
      if (fir_act && !stub_hang) begin
        fir_ready <= 1'b0;
        fir_y     <= fir_x + 16'd1;
        stub_cnt  <= stub_lat;
      end
    end else if (stub_cnt <= 1) begin
      fir_ready <= 1'b1;
    end else begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  // Scoreboard queues.
  typedef struct packed {
    logic [15:0] y;
    logic [15:0] cnt;
  } res_t;

  res_t        exp_res[$];
  logic [15:0] exp_x[$];
  logic [15:0] exp_cnt = '0;
  logic [15:0] last_x  = '0;
  res_t        mon_r;
  bit          prev_act = 1'b0;
  int          act_seen = 0;

  // Result monitor: one compare per consumed result.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_res.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got out_data=0x%0h, required no result", out_data);
      end else begin
        mon_r = exp_res.pop_front();
        check("out_data", {16'h0, out_data}, {16'h0, mon_r.y});
        check("sample_cnt_at_result", {16'h0, sample_cnt}, {16'h0, mon_r.cnt});
      end
    end
  end

  // Issue monitor: act shape, issue order, backpressure and fir_x stability.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_act = 1'b0;
    end else begin
      if (fir_act) begin
        act_seen++;
        check("act_single_cycle", {31'h0, prev_act}, 32'h0);
        check("act_while_out_valid", {31'h0, out_valid}, 32'h0);
        if (exp_x.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_issue: got fir_x=0x%0h, required no issue", fir_x);
        end else begin
          last_x = exp_x.pop_front();
          check("fir_x_issue", {16'h0, fir_x}, {16'h0, last_x});
        end
      end else if (!fir_ready) begin
        check("fir_x_held", {16'h0, fir_x}, {16'h0, last_x});
      end
      prev_act = fir_act;
    end
  end

  // Drive one sample for one cycle; called at a negedge. acc is whether the
  // FIFO must accept it, y the hand-computed filter result, has_res whether a
  // result is expected.
  task automatic push(input logic [15:0] d, input logic [15:0] y, input bit acc, input bit has_res);
    in_data  = d;
    in_valid = 1'b1;
    check("in_ready_at_push", {31'h0, in_ready}, {31'h0, acc});
    if (acc) begin
      exp_x.push_back(d);
      if (has_res) begin
        exp_cnt = exp_cnt + 16'd1;
        exp_res.push_back('{y: y, cnt: exp_cnt});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (exp_res.size() == 0 && exp_x.size() == 0) done = 1'b1;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d results pending, required 0", tag, exp_res.size());
    end
  endtask

  task automatic wait_level(input string tag, input int limit, input bit want_valid);
    // want_valid=1: wait for out_valid high; 0: wait for fir_ready low.
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (want_valid ? out_valid : !fir_ready) seen = 1'b1;
      else @(negedge clk);
    end
    check(tag, {31'h0, seen}, 32'h1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},   {31'h0, in_ready},   32'h1);
    check({tag, "_fir_act"},    {31'h0, fir_act},    32'h0);
    check({tag, "_fir_x"},      {16'h0, fir_x},      32'h0);
    check({tag, "_out_data"},   {16'h0, out_data},   32'h0);
    check({tag, "_out_valid"},  {31'h0, out_valid},  32'h0);
    check({tag, "_err"},        {31'h0, err},        32'h0);
    check({tag, "_sample_cnt"}, {16'h0, sample_cnt}, 32'h0);
  endtask

  int act_base;
  int cyc;

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    reset_n = 1'b1;
    @(negedge clk);

    // Single sample through a 36-cycle filter.
    stub_lat = 36;
    push(16'h1234, 16'h1235, 1'b1, 1'b1);
    wait_drain(200, "single");
    @(negedge clk);
    check("single_out_valid_clear", {31'h0, out_valid}, 32'h0);

    // Hold a result, fill the FIFO, drop the fifth push, then release.
    out_ready = 1'b0;
    push(16'h1000, 16'h1001, 1'b1, 1'b1);
    wait_level("bp_result_held", 200, 1'b1);
    act_base = act_seen;
    push(16'h0001, 16'h0002, 1'b1, 1'b1);
    push(16'h0002, 16'h0003, 1'b1, 1'b1);
    push(16'h0003, 16'h0004, 1'b1, 1'b1);
    push(16'h0004, 16'h0005, 1'b1, 1'b1);
    push(16'h0005, 16'h0006, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("bp_no_issue", act_seen - act_base, 32'h0);
    check("bp_hold_data", {16'h0, out_data}, 32'h1001);
    check("bp_fifo_full", {31'h0, in_ready}, 32'h0);
    out_ready = 1'b1;
    wait_drain(1000, "fifo_full");
    check("fifo_full_cnt", {16'h0, sample_cnt}, 32'h6);

    // Timeout: the filter never acknowledges the first sample.
    stub_hang = 1'b1;
    push(16'h00AA, 16'h0000, 1'b1, 1'b0);
    push(16'h00BB, 16'h00BC, 1'b1, 1'b1);
    cyc = 0;
    for (int i = 0; i < 20 && !fir_act; i++) @(negedge clk);
    @(negedge clk);
    while (!err && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    stub_hang = 1'b0;
    check("tmo_wait_cycles", cyc, 32'd63);
    check("tmo_err", {31'h0, err}, 32'h1);
    check("tmo_out_valid", {31'h0, out_valid}, 32'h0);
    check("tmo_cnt_unchanged", {16'h0, sample_cnt}, 32'h6);
    wait_drain(200, "after_timeout");
    check("err_sticky", {31'h0, err}, 32'h1);

    // Reset in the middle of a transaction.
    push(16'h5555, 16'h0000, 1'b1, 1'b0);
    wait_level("rst_mid_busy", 50, 1'b0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    exp_res.delete();
    exp_x.delete();
    exp_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    check("rst_no_result", {31'h0, out_valid}, 32'h0);

    // Counter wrap with a fast filter; the count is preloaded near the top.
    stub_lat = 2;
    push(16'h0020, 16'h0021, 1'b1, 1'b1);
    wait_drain(100, "fast");
    force dut.sample_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.sample_cnt;
    exp_cnt = 16'hFFFE;
    push(16'h0030, 16'h0031, 1'b1, 1'b1);
    push(16'h0031, 16'h0032, 1'b1, 1'b1);
    wait_drain(200, "wrap");
    check("wrap_cnt", {16'h0, sample_cnt}, 32'h0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
